mio_kbd_rx: RTL and testbench

MIO_KBD_RX -- requirements
Module: mio_kbd_rx

---
 rtl/mio_kbd_rx_if.sv | 34 +++
 rtl/mio_kbd_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_mio_kbd_rx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mio_kbd_rx_if.sv
// ----------------------------------------------------------------------------
// mio_kbd_rx_if
// MIO bus side of the PS/2 keyboard receiver: read strobe in, FIFO head byte,
// occupancy and status flags out.
//   rdn        : active-low read strobe (bus -> receiver)
//   data       : FIFO head byte (receiver -> bus)
//   ready      : FIFO not empty
//   overflow   : sticky, a byte was dropped because the FIFO was full
//   count      : FIFO occupancy, $clog2(FIFO_DEPTH)+1 bits
//   parity_err : sticky, a frame was rejected for bad parity
// Modports: master = bus side, slave = receiver side.
// ----------------------------------------------------------------------------
interface mio_kbd_rx_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          rdn;
    logic [7:0]    data;
    logic          ready;
    logic          overflow;
    logic [CW-1:0] count;
    logic          parity_err;

    modport master (
        output rdn,
        input  data, ready, overflow, count, parity_err
    );

    modport slave (
        input  rdn,
        output data, ready, overflow, count, parity_err
    );
endinterface

// File: rtl/mio_kbd_rx.sv
// ----------------------------------------------------------------------------
// mio_kbd_rx
// PS/2 keyboard receiver with a first-word fall-through receive FIFO.
// ps2_clk/ps2_data are synchronised, ps2_clk is glitch filtered, and each
// filtered falling edge clocks one frame bit into an 11-bit frame FSM
// (start, 8 data LSB first, odd parity, stop). Accepted bytes go to the FIFO.
//
// Ports:
//   clk      : system clock, all state on rising edge
//   clrn     : asynchronous active-low reset
//   ps2_clk  : asynchronous PS/2 clock line
//   ps2_data : asynchronous PS/2 data line
//   bus      : mio_kbd_rx_if.slave (rdn, data, ready, overflow, count,
//              parity_err)
//
// Configuration:
//   MIO_KBD_PARITY_CHK_EN : when defined, bad-parity frames are dropped and
//                           set parity_err; otherwise parity is ignored and
//                           parity_err is tied low.
// ----------------------------------------------------------------------------
module mio_kbd_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    mio_kbd_rx_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Synchronisers and ps2_clk filter
    // ------------------------------------------------------------------
    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    logic          flt_clk_q, flt_clk_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          strobe;

    always_comb begin
        clk_meta_d = ps2_clk;
        clk_sync_d = clk_meta_q;
        dat_meta_d = ps2_data;
        dat_sync_d = dat_meta_q;
    end

    // The filtered level flips once the synchronised sample has differed
    // from it for FILTER_LEN consecutive cycles; any agreeing sample
    // restarts the run. A 1->0 flip is the bit strobe.
    always_comb begin
        flt_clk_d = flt_clk_q;
        flt_cnt_d = flt_cnt_q;
        strobe    = 1'b0;
        if (clk_sync_q == flt_clk_q) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q == FLT_LAST) begin
            flt_clk_d = clk_sync_q;
            flt_cnt_d = '0;
            strobe    = ~clk_sync_q;
        end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_q, par_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          frame_ok;
    logic          par_set;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (strobe) begin
            unique case (state_q)
                ST_IDLE:   if (!dat_sync_q) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && wdog_q == WD_LAST) begin
            state_d = ST_IDLE;
        end
    end

    // par_q holds the XOR of the data bits and, by STOP, the parity bit too;
    // odd parity therefore means par_q == 1 at the stop strobe.
    always_comb begin
        frame_ok = 1'b0;
        par_set  = 1'b0;
        if (strobe && state_q == ST_STOP && dat_sync_q) begin
`ifdef MIO_KBD_PARITY_CHK_EN
            frame_ok = par_q;
            par_set  = ~par_q;
`else
            frame_ok = 1'b1;
`endif
        end
    end

`ifndef MIO_KBD_PARITY_CHK_EN
    logic unused_par;
    assign unused_par = par_q;
`endif

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        wdog_d    = (state_q == ST_IDLE || strobe) ? '0 : wdog_q + 1'b1;
        if (strobe) begin
            unique case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                end
                ST_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    par_d     = par_q ^ dat_sync_q;
                end
                ST_PARITY: par_d = par_q ^ dat_sync_q;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic          rdn_q, rdn_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, perr_q, perr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          pop, do_push, ovf_set, full;

    always_comb begin
        rdn_d    = bus.rdn;
        full     = (count_q == CNT_FULL);
        pop      = rdn_q & ~bus.rdn & (count_q != '0);
        do_push  = frame_ok & (~full | pop);
        ovf_set  = frame_ok & full & ~pop;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !do_push) count_d = count_q - 1'b1;
        // A set in the same cycle wins over the clear-on-pop.
        ovf_d  = ovf_set ? 1'b1 : (pop ? 1'b0 : ovf_q);
        perr_d = par_set ? 1'b1 : (pop ? 1'b0 : perr_q);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            flt_clk_q  <= 1'b1;
            flt_cnt_q  <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            wdog_q     <= '0;
            rdn_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
            flt_clk_q  <= flt_clk_d;
            flt_cnt_q  <= flt_cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            wdog_q     <= wdog_d;
            rdn_q      <= rdn_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bus.ready      = (count_q != '0);
    assign bus.data       = bus.ready ? mem_q[rd_ptr_q] : '0;
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;
`ifdef MIO_KBD_PARITY_CHK_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_mio_kbd_rx.sv
// ----------------------------------------------------------------------------
// tb_mio_kbd_rx
// Directed bench for mio_kbd_rx: 10 MHz clock, PS/2 bit period 200 clocks
// (20 us), FILTER_LEN 8, TIMEOUT shortened to 2000 clocks.
// ----------------------------------------------------------------------------
module tb_mio_kbd_rx;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FLEN  = 8;
    localparam int unsigned TOUT  = 2000;

    logic clk      = 1'b0;
    logic clrn     = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    mio_kbd_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    mio_kbd_rx #(
        .FIFO_DEPTH(DEPTH),
        .FILTER_LEN(FLEN),
        .TIMEOUT   (TOUT)
    ) dut (
        .clk     (clk),
        .clrn    (clrn),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .bus     (bus)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;

    logic [7:0] ovb [10];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(50);
        ps2_clk = 1'b0;
        wait_cyc(100);
        ps2_clk = 1'b1;
        wait_cyc(50);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) ps2_bit(bits[i]);
    endtask

    // Sends a full frame; the stop bit is driven inline so the bench can
    // measure ready latency and optionally pop in the exact push cycle.
    task automatic send_frame(input logic [7:0] d, input logic par_bad, input bit pop_sync);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ par_bad, d, 1'b0};
        send_bits(f, 10);
        ps2_data = 1'b1;
        wait_cyc(50);
        ps2_clk = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (pop_sync && i == 9)  bus.rdn = 1'b0;
            if (pop_sync && i == 11) bus.rdn = 1'b1;
            if (lat == 0 && bus.ready) lat = i;
        end
        ps2_clk = 1'b1;
        wait_cyc(50);
    endtask

    task automatic pop_pulse();
        @(negedge clk);
        bus.rdn = 1'b0;
        wait_cyc(3);
        bus.rdn = 1'b1;
        wait_cyc(2);
    endtask

    initial begin
        ovb = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h55, 8'hAA, 8'h01, 8'h80, 8'hC3, 8'h96};
        bus.rdn = 1'b1;
        wait_cyc(5);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovf",   32'(bus.overflow), 32'd0);
        chk("rst_perr",  32'(bus.parity_err), 32'd0);
        clrn = 1'b1;
        wait_cyc(5);

        // Single frame: ready 10 clocks after the stop-bit falling edge
        // (2 sync + 8 filter samples, strobe cycle, push edge).
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("f1_lat",   32'(lat), 32'd10);
        chk("f1_ready", 32'(bus.ready), 32'd1);
        chk("f1_data",  32'(bus.data), 32'h1C);
        chk("f1_count", 32'(bus.count), 32'd1);
        pop_pulse();
        chk("f1_pop_ready", 32'(bus.ready), 32'd0);
        chk("f1_pop_count", 32'(bus.count), 32'd0);

        // Pop on empty FIFO is ignored
        pop_pulse();
        chk("empty_pop_count", 32'(bus.count), 32'd0);
        chk("empty_pop_ovf",   32'(bus.overflow), 32'd0);

        // Two frames queued
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("f2_data",  32'(bus.data), 32'hF0);
        chk("f2_count", 32'(bus.count), 32'd2);
        pop_pulse();
        chk("f2_pop_data",  32'(bus.data), 32'h1C);
        chk("f2_pop_count", 32'(bus.count), 32'd1);
        pop_pulse();
        chk("f2_empty", 32'(bus.count), 32'd0);

        // Short ps2_clk glitch, then a strobe with start bit 1: both ignored
        ps2_clk = 1'b0;
        wait_cyc(4);
        ps2_clk = 1'b1;
        wait_cyc(20);
        ps2_bit(1'b1);
        chk("glitch_count", 32'(bus.count), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("glitch_data",  32'(bus.data), 32'h3C);
        chk("glitch_count2", 32'(bus.count), 32'd1);
        pop_pulse();

        // Overflow: 9 frames into 8 entries, C3 is dropped
        for (int i = 0; i < 9; i++) send_frame(ovb[i], 1'b0, 1'b0);
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_flag",  32'(bus.overflow), 32'd1);
        chk("ovf_head",  32'(bus.data), 32'h00);
        // Push and pop in the same cycle while full
        send_frame(ovb[9], 1'b0, 1'b1);
        chk("simul_count", 32'(bus.count), 32'd8);
        chk("simul_ovf",   32'(bus.overflow), 32'd0);
        for (int i = 1; i < 8; i++) begin
            chk("ovf_pop_data", 32'(bus.data), 32'(ovb[i]));
            pop_pulse();
        end
        chk("ovf_last_data", 32'(bus.data), 32'h96);
        pop_pulse();
        chk("ovf_drained", 32'(bus.count), 32'd0);

        // Bad parity
        send_frame(8'h1C, 1'b1, 1'b0);
`ifdef MIO_KBD_PARITY_CHK_EN
        chk("par_count", 32'(bus.count), 32'd0);
        chk("par_err",   32'(bus.parity_err), 32'd1);
        send_frame(8'h4B, 1'b0, 1'b0);
        chk("par_err_hold", 32'(bus.parity_err), 32'd1);
        pop_pulse();
        chk("par_err_clr", 32'(bus.parity_err), 32'd0);
`else
        chk("par_data",  32'(bus.data), 32'h1C);
        chk("par_count", 32'(bus.count), 32'd1);
        chk("par_err",   32'(bus.parity_err), 32'd0);
        pop_pulse();
`endif
        chk("par_empty", 32'(bus.count), 32'd0);

        // Timeout: start + 4 data bits, stall, then a clean frame
        send_bits(11'h01E, 5);
        wait_cyc(TOUT + 10);
        send_frame(8'h29, 1'b0, 1'b0);
        chk("tmo_count", 32'(bus.count), 32'd1);
        chk("tmo_data",  32'(bus.data), 32'h29);
        pop_pulse();

        // Reset mid-frame with a byte already queued
        send_frame(8'h33, 1'b0, 1'b0);
        send_bits(11'h01A, 6);
        clrn = 1'b0;
        wait_cyc(3);
        chk("mrst_ready", 32'(bus.ready), 32'd0);
        chk("mrst_count", 32'(bus.count), 32'd0);
        chk("mrst_ovf",   32'(bus.overflow), 32'd0);
        chk("mrst_perr",  32'(bus.parity_err), 32'd0);
        chk("mrst_data",  32'(bus.data), 32'd0);
        clrn = 1'b1;
        wait_cyc(5);
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("post_rst_data",  32'(bus.data), 32'h5A);
        chk("post_rst_count", 32'(bus.count), 32'd1);
        pop_pulse();
        chk("post_rst_empty", 32'(bus.count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
